// File: rtl/keypad_frontend.sv
// -----------------------------------------------------------------------------
// keypad_frontend
//
// Purpose:
//   Front end for a 4x4 matrix keypad. It has three parts:
//   - a combinational row-sense model of the keypad, driven by the scanner's
//     column lines,
//   - a multi-stage row synchronizer into the clk domain,
//   - four independent 1-bit debouncers, one for each bit of the scanner's
//     raw key code.
//
// Parameters:
//   SYNC_STAGES - number of flip-flop stages in the row synchronizer (>= 2)
//   DB_CYCLES   - number of consecutive identical samples a debouncer needs
//                 before its output follows the input (2..255)
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous, active-high reset
//   key     in  16  key states, 1 = pressed, bit index = 4*row + col
//   col     in   4  column drive from the scanner, active-high
//   code    in   4  raw key code from the scanner
//   row     out  4  row sense lines, combinational from key and col
//   s_row   out  4  row lines synchronized to clk
//   code_db out  4  debounced copy of code
// -----------------------------------------------------------------------------
module keypad_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key,
    input  logic [3:0]  col,
    input  logic [3:0]  code,
    output logic [3:0]  row,
    output logic [3:0]  s_row,
    output logic [3:0]  code_db
);

    localparam logic [7:0] DB_MAX = 8'(DB_CYCLES);

    // Row model: a pressed key ties its column line to its row line.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) begin
            row[r] = |(key[4*r +: 4] & col);
        end
    end

    // Synchronizer stages: sync_p[0] captures row, the last stage drives s_row.
    logic [3:0] sync_p [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= row;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign s_row = sync_p[SYNC_STAGES-1];

    // Debouncers: smp holds the previous sample, cnt is the length of the
    // current run of identical samples. A new value restarts the run at 1.
    // The output commits on the edge where the run reaches DB_CYCLES, and
    // the counter then saturates so a stable input causes no further updates.
    logic [3:0] smp;
    logic [7:0] cnt [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            smp     <= '0;
            code_db <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (code[i] != smp[i]) begin
                    smp[i] <= code[i];
                    cnt[i] <= 8'd1;
                end else if (cnt[i] != DB_MAX) begin
                    cnt[i] <= cnt[i] + 8'd1;
                    if (cnt[i] + 8'd1 == DB_MAX) begin
                        code_db[i] <= smp[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_frontend.sv
// -----------------------------------------------------------------------------
// tb_keypad_frontend
//
// Self-checking bench for keypad_frontend. Each cycle drives inputs just after
// a falling edge, checks row combinationally, pushes the expected post-edge
// s_row/code_db onto a scoreboard, and pops/compares them after the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_frontend;

    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key;
    logic [3:0]  col;
    logic [3:0]  code;
    logic [3:0]  row;
    logic [3:0]  s_row;
    logic [3:0]  code_db;

    keypad_frontend #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .col     (col),
        .code    (code),
        .row     (row),
        .s_row   (s_row),
        .code_db (code_db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] s_row;
        logic [3:0] code_db;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] sync_m [SYNC_STAGES];
    bit         hist [4][$];
    logic [3:0] db_m;

    // Reference keypad: walk every key, set its row when its column is driven.
    function automatic logic [3:0] row_ref(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i] && c[i % 4]) r[i / 4] = 1'b1;
        end
        return r;
    endfunction

    task automatic cycle(input logic r, input logic [15:0] k, input logic [3:0] c,
                         input logic [3:0] cd);
        exp_t e;
        bool_same_t: begin end
        rst  = r;
        key  = k;
        col  = c;
        code = cd;
        #1;
        check("row", {12'd0, row}, {12'd0, row_ref(k, c)});

        // Model of the coming rising edge.
        if (r) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_m[i] = '0;
            for (int b = 0; b < 4; b++) hist[b].delete();
            db_m = '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
            sync_m[0] = row_ref(k, c);
            // Output follows once the last DB_CYCLES samples are all identical.
            for (int b = 0; b < 4; b++) begin
                hist[b].push_back(cd[b]);
                if (hist[b].size() > DB_CYCLES) void'(hist[b].pop_front());
                if (hist[b].size() == DB_CYCLES) begin
                    bit same;
                    same = 1'b1;
                    for (int j = 1; j < DB_CYCLES; j++) begin
                        if (hist[b][j] != hist[b][0]) same = 1'b0;
                    end
                    if (same) db_m[b] = hist[b][0];
                end
            end
        end
        e.s_row   = sync_m[SYNC_STAGES-1];
        e.code_db = db_m;
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("s_row",   {12'd0, s_row},   {12'd0, e.s_row});
        check("code_db", {12'd0, code_db}, {12'd0, e.code_db});
    endtask

    initial begin
        int hold;
        logic [3:0] cd;

        rst  = 1'b1;
        key  = '0;
        col  = '0;
        code = '0;
        db_m = '0;
        for (int i = 0; i < SYNC_STAGES; i++) sync_m[i] = '0;
        @(negedge clk);

        // Reset state.
        cycle(1'b1, 16'h0000, 4'h0, 4'h0);
        cycle(1'b1, 16'h0000, 4'h0, 4'h0);
        check("reset_s_row",   {12'd0, s_row},   16'h0000);
        check("reset_code_db", {12'd0, code_db}, 16'h0000);

        // Single key, matching and non-matching column.
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0001, 4'b0001, 4'h0);
        check("single_key_s_row", {12'd0, s_row}, 16'h0001);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0001, 4'b0010, 4'h0);

        // One-hot key walk with all columns driven.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 6; i++) cycle(1'b0, 16'(1) << k, 4'b1111, 4'h0);
            for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0000, 4'b1111, 4'h0);
        end

        // Debounce of a full code and its release.
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'hA);
        check("code_a_held", {12'd0, code_db}, 16'h000A);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h0);
        check("code_released", {12'd0, code_db}, 16'h0000);

        // Glitch shorter than DB_CYCLES, then a pulse of exactly DB_CYCLES.
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h0);
        check("pulse3", {15'd0, code_db[0]}, 16'h0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h1);
        check("pulse4", {15'd0, code_db[0]}, 16'h0001);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h0);

        // Reset while the debounced output is high with the input still high.
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'hF);
        cycle(1'b1, 16'h0000, 4'h0, 4'hF);
        check("rst_clears_db", {12'd0, code_db}, 16'h0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 4'h0, 4'hF);
        check("db_not_early", {12'd0, code_db}, 16'h0000);
        cycle(1'b0, 16'h0000, 4'h0, 4'hF);
        check("db_after_release", {12'd0, code_db}, 16'h000F);

        // Reset mid-count aborts it.
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h5);
        cycle(1'b1, 16'h0000, 4'h0, 4'h5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h5);
        check("mid_count_rst", {12'd0, code_db}, 16'h0000);
        cycle(1'b0, 16'h0000, 4'h0, 4'h5);

        // Corner keys with two columns, then release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h8001, 4'b1001, 4'h0);
        check("corner_row", {12'd0, row}, 16'h0009);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 4'b1001, 4'h0);

        // Random traffic, with the code held for random run lengths.
        hold = 0;
        cd   = '0;
        for (int n = 0; n < 300; n++) begin
            if (hold == 0) begin
                cd   = 4'($urandom);
                hold = $urandom_range(1, 7);
            end
            hold--;
            cycle(($urandom_range(0, 49) == 0), 16'($urandom), 4'($urandom), cd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
